memoryc: RTL and testbench

MEMORYC -- requirements
Module: memoryc

---
 rtl/memoryc.sv | 117 +++++++++++
 tb/tb_memoryc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoryc.sv
// Y86 memory stage: combinational data-memory read and address check,
// clocked memory write, and the M->W pipeline register.
module memoryc #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_destE,
  input  logic [3:0]  M_destM,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_destE,
  output logic [3:0]  W_destM
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] REG_NONE = 4'hF;

  logic [63:0]   mem [MEM_WORDS];
  logic [63:0]   mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic          addr_ok;
  logic          mem_we;
  logic [AW-1:0] addr_idx;

  // M_Cnd is carried by the stage interface but plays no part in memory access.
  logic unused_cnd;
  assign unused_cnd = M_Cnd;

  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (M_icode)
      4'h4, 4'h8, 4'hA: begin
        mem_addr  = M_valE;
        mem_write = 1'b1;
      end
      4'h5: begin
        mem_addr = M_valE;
        mem_read = 1'b1;
      end
      4'h9, 4'hB: begin
        mem_addr = M_valA;
        mem_read = 1'b1;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare so large addresses never alias into the array.
  assign addr_ok  = (mem_addr < 64'(MEM_WORDS));
  assign addr_idx = mem_addr[AW-1:0];
  assign mem_we   = mem_write && addr_ok && (M_stat == STAT_AOK);

  assign m_valM = (mem_read && addr_ok) ? mem[addr_idx] : '0;
  assign m_stat = ((mem_read || mem_write) && !addr_ok) ? STAT_ADR : M_stat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[addr_idx] <= M_valA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_destE <= REG_NONE;
      W_destM <= REG_NONE;
    end else if (W_stall) begin
      W_stat  <= W_stat;
      W_icode <= W_icode;
      W_valE  <= W_valE;
      W_valM  <= W_valM;
      W_destE <= W_destE;
      W_destM <= W_destM;
    end else if (W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_destE <= REG_NONE;
      W_destM <= REG_NONE;
    end else begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_destE <= M_destE;
      W_destM <= M_destM;
    end
  end

endmodule

// File: tb/tb_memoryc.sv
// Self-checking bench for memoryc: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
module tb_memoryc;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        W_stall, W_bubble;
  logic [3:0]  M_stat, M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_destE, M_destM;
  logic [63:0] m_valM;
  logic [3:0]  m_stat;
  logic [3:0]  W_stat, W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_destE, W_destM;

  memoryc #(.MEM_WORDS(N)) dut (
    .clk(clk), .reset(reset), .W_stall(W_stall), .W_bubble(W_bubble),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_destE(M_destE), .M_destM(M_destM),
    .m_valM(m_valM), .m_stat(m_stat),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_destE(W_destE), .W_destM(W_destM)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference state
  logic [63:0] mem_m [N];
  logic [3:0]  ws_m, wi_m, wde_m, wdm_m;
  logic [63:0] wve_m, wvm_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit is_rd(input logic [3:0] ic);
    return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
  endfunction

  function automatic bit is_wr(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
  endfunction

  function automatic logic [63:0] acc_addr();
    return ((M_icode == 4'h9) || (M_icode == 4'hB)) ? M_valA : M_valE;
  endfunction

  function automatic bit in_range(input logic [63:0] a);
    return a < 64'(N);
  endfunction

  function automatic logic [3:0] exp_stat();
    if ((is_rd(M_icode) || is_wr(M_icode)) && !in_range(acc_addr())) return 4'h3;
    return M_stat;
  endfunction

  function automatic logic [63:0] exp_rd();
    logic [63:0] a;
    a = acc_addr();
    if (is_rd(M_icode) && in_range(a)) return mem_m[int'(a)];
    return 64'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem_m[i] = 64'd0;
    ws_m = 4'h1; wi_m = 4'h1; wve_m = 64'd0; wvm_m = 64'd0; wde_m = 4'hF; wdm_m = 4'hF;
  endtask

  task automatic model_edge();
    logic [63:0] rd, a;
    logic [3:0]  st;
    rd = exp_rd();
    st = exp_stat();
    a  = acc_addr();
    if (is_wr(M_icode) && in_range(a) && M_stat == 4'h1) mem_m[int'(a)] = M_valA;
    if (W_stall) begin
    end else if (W_bubble) begin
      ws_m = 4'h1; wi_m = 4'h1; wve_m = 64'd0; wvm_m = 64'd0; wde_m = 4'hF; wdm_m = 4'hF;
    end else begin
      ws_m = st; wi_m = M_icode; wve_m = M_valE; wvm_m = rd; wde_m = M_destE; wdm_m = M_destM;
    end
  endtask

  // Advance one clock: model follows the edge, then inputs may change at +1.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [3:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm);
    M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_destE = de; M_destM = dm;
    M_Cnd = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    set_in(4'h1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("m_valM",  m_valM,  exp_rd());
      chk("m_stat",  64'(m_stat),  64'(exp_stat()));
      chk("W_stat",  64'(W_stat),  64'(ws_m));
      chk("W_icode", 64'(W_icode), 64'(wi_m));
      chk("W_valE",  W_valE,  wve_m);
      chk("W_valM",  W_valM,  wvm_m);
      chk("W_destE", 64'(W_destE), 64'(wde_m));
      chk("W_destM", 64'(W_destM), 64'(wdm_m));
    end
  end

  initial begin
    logic [63:0] a;
    reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    idle();
    model_reset();
    #2;
    chk("rst_W_icode", 64'(W_icode), 64'h1);
    chk("rst_W_stat",  64'(W_stat),  64'h1);
    chk("rst_W_destE", 64'(W_destE), 64'hF);
    chk("rst_W_destM", 64'(W_destM), 64'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // store then load of the same word
    set_in(4'h1, 4'h4, 64'd10, 64'h1234, 4'hF, 4'hF);
    cycle();
    set_in(4'h1, 4'h5, 64'd10, 64'd0, 4'hF, 4'h2);
    #1;
    chk("ld_m_valM", m_valM, 64'h1234);
    chk("ld_m_stat", 64'(m_stat), 64'h1);
    cycle();
    chk("ld_W_valM", W_valM, 64'h1234);

    // out-of-range push
    set_in(4'h1, 4'hA, 64'd256, 64'hDEAD, 4'h4, 4'hF);
    #1;
    chk("oor_m_stat", 64'(m_stat), 64'h3);
    cycle();
    chk("oor_W_stat", 64'(W_stat), 64'h3);
    set_in(4'h1, 4'h5, 64'd255, 64'd0, 4'hF, 4'h1);
    #1;
    chk("oor_mem255", m_valM, 64'h0);
    cycle();

    // high address bits must not alias into the array
    set_in(4'h1, 4'h5, 64'h1_0000_000A, 64'd0, 4'hF, 4'h1);
    #1;
    chk("trunc_m_stat", 64'(m_stat), 64'h3);
    chk("trunc_m_valM", m_valM, 64'h0);
    cycle();

    // pop address comes from valA
    set_in(4'h1, 4'h4, 64'd20, 64'h55, 4'hF, 4'hF);
    cycle();
    set_in(4'h1, 4'hB, 64'd21, 64'd20, 4'h4, 4'h3);
    #1;
    chk("pop_m_valM", m_valM, 64'h55);
    cycle();
    chk("pop_W_valE", W_valE, 64'd21);
    chk("pop_W_valM", W_valM, 64'h55);

    // stall+bubble resolves as stall, then bubble alone
    set_in(4'h1, 4'h6, 64'd7, 64'd1, 4'h3, 4'hF);
    cycle();
    chk("opq_W_icode", 64'(W_icode), 64'h6);
    set_in(4'h1, 4'h2, 64'd9, 64'd9, 4'h5, 4'hF);
    W_stall = 1'b1; W_bubble = 1'b1;
    cycle();
    cycle();
    chk("stl_W_icode", 64'(W_icode), 64'h6);
    chk("stl_W_destE", 64'(W_destE), 64'h3);
    W_stall = 1'b0;
    cycle();
    chk("bub_W_icode", 64'(W_icode), 64'h1);
    chk("bub_W_destE", 64'(W_destE), 64'hF);
    chk("bub_W_destM", 64'(W_destM), 64'hF);
    W_bubble = 1'b0;

    // asynchronous reset between edges
    set_in(4'h1, 4'h4, 64'd3, 64'd7, 4'hF, 4'hF);
    cycle();
    set_in(4'h1, 4'h6, 64'd1, 64'd1, 4'h2, 4'hF);
    cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_W_icode", 64'(W_icode), 64'h1);
    model_reset();
    reset = 1'b0;
    set_in(4'h1, 4'h5, 64'd3, 64'd0, 4'hF, 4'h1);
    #1;
    chk("arst_mem3", m_valM, 64'h0);
    cycle();

    // halted store must not write
    set_in(4'h2, 4'h4, 64'd5, 64'd99, 4'hF, 4'hF);
    cycle();
    chk("hlt_W_stat", 64'(W_stat), 64'h2);
    set_in(4'h1, 4'h5, 64'd5, 64'd0, 4'hF, 4'h1);
    #1;
    chk("hlt_mem5", m_valM, 64'h0);
    cycle();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] st;
      case ($urandom_range(0, 9))
        0: st = 4'h2;
        1: st = 4'h3;
        2: st = 4'h4;
        default: st = 4'h1;
      endcase
      case ($urandom_range(0, 9))
        0: a = 64'($urandom_range(250, 262));
        1: a = {32'($urandom_range(1, 3)), 32'($urandom_range(0, 31))};
        2: a = 64'hFFFF_FFFF_FFFF_FFFF;
        3: a = 64'($urandom_range(0, 255));
        default: a = 64'($urandom_range(0, 31));
      endcase
      set_in(st, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) != 0) ? a : {$urandom, $urandom},
             ($urandom_range(0, 1) != 0) ? a : {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      W_stall  = ($urandom_range(0, 7) == 0);
      W_bubble = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        reset = 1'b0;
      end
      cycle();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, limit 500000 reached");
    $fatal(1);
  end

endmodule
